// File: rtl/pipeline_hazard_sequencer.sv
// Pipeline control sequencer: merges memory freezes, load-use stalls and annulled-branch
// squashes into one prioritised FSM driving PC / IF/ID / ID/EX controls, plus saturating counters.
module pipeline_hazard_sequencer #(
    parameter int STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             system_reset,
    input  logic             ID_branch_instr,
    input  logic             a,
    input  logic             condition_handler_instr,
    input  logic             load_use_hazard,
    input  logic             mem_busy,
    output logic             pc_ld,
    output logic             if_id_ld,
    output logic             if_id_reset,
    output logic             id_ex_nop,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] annul_count,
    output logic [1:0]       state_dbg_o
);

    localparam int MAXC = (STALL_CYCLES > FLUSH_CYCLES) ? STALL_CYCLES : FLUSH_CYCLES;
    localparam int RW   = $clog2(MAXC + 1);
    localparam logic [RW-1:0] STALL_REM = RW'(STALL_CYCLES - 1);
    localparam logic [RW-1:0] FLUSH_REM = RW'(FLUSH_CYCLES - 1);
    localparam logic [RW-1:0] REM_ONE   = RW'(1);

    typedef enum logic [1:0] {RUN, LU_STALL, FLUSH, MEM_WAIT} state_t;

    // Handshake-free block: every control is a level valid for the current cycle only.
    state_t           state_q, state_d, ret_q, ret_d;
    logic [RW-1:0]    rem_q, rem_d;
    logic [CNT_W-1:0] stall_cnt_q, annul_cnt_q;
    logic             annul;

    assign annul       = ID_branch_instr & a & ~condition_handler_instr;
    assign state_dbg_o = state_q;
    assign stall_count = stall_cnt_q;
    assign annul_count = annul_cnt_q;

    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        rem_d       = rem_q;
        pc_ld       = 1'b0;
        if_id_ld    = 1'b0;
        if_id_reset = 1'b0;
        id_ex_nop   = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_busy) begin
                    ret_d   = RUN;
                    state_d = MEM_WAIT;
                end else if (load_use_hazard) begin
                    id_ex_nop = 1'b1;
                    if (STALL_CYCLES > 1) begin
                        rem_d   = STALL_REM;
                        state_d = LU_STALL;
                    end
                end else if (annul) begin
                    if_id_reset = 1'b1;
                    pc_ld       = 1'b1;
                    if_id_ld    = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        rem_d   = FLUSH_REM;
                        state_d = FLUSH;
                    end
                end else begin
                    pc_ld    = 1'b1;
                    if_id_ld = 1'b1;
                end
            end
            LU_STALL: begin
                if (mem_busy) begin
                    ret_d   = LU_STALL;
                    state_d = MEM_WAIT;
                end else begin
                    id_ex_nop = 1'b1;
                    rem_d     = rem_q - 1'b1;
                    if (rem_q == REM_ONE) state_d = RUN;
                end
            end
            FLUSH: begin
                if (mem_busy) begin
                    ret_d   = FLUSH;
                    state_d = MEM_WAIT;
                end else begin
                    if_id_reset = 1'b1;
                    pc_ld       = 1'b1;
                    if_id_ld    = 1'b1;
                    rem_d       = rem_q - 1'b1;
                    if (rem_q == REM_ONE) state_d = RUN;
                end
            end
            MEM_WAIT: begin
                // The release cycle still shows all controls low; resume on the next clock.
                if (!mem_busy) state_d = ret_q;
            end
            default: state_d = RUN;
        endcase
        if (system_reset) begin
            pc_ld       = 1'b0;
            if_id_ld    = 1'b0;
            if_id_reset = 1'b1;
            id_ex_nop   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge system_reset) begin
        if (system_reset) begin
            state_q     <= RUN;
            ret_q       <= RUN;
            rem_q       <= '0;
            stall_cnt_q <= '0;
            annul_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            rem_q   <= rem_d;
            if (id_ex_nop && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + 1'b1;
            if (if_id_reset && !system_reset && (annul_cnt_q != {CNT_W{1'b1}}))
                annul_cnt_q <= annul_cnt_q + 1'b1;
        end
    end

endmodule
